scs8hd_tmr_vote_reg: RTL and testbench
======================================

SCS8HD_TMR_VOTE_REG -- requirements
Module: scs8hd_tmr_vote_reg

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, giving the bit width of each replicated lane and of the voted output.
REQ-002 The block SHALL provide parameter CNT_W, default 4, giving the width of the error counter.
REQ-003 The block SHALL have input CLK, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input RESET, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have inputs A, B and C, width WIDTH each: the three replicated lanes feeding the voter.
REQ-006 The block SHALL have input IN_VALID, width 1: lanes A/B/C carry a word.
REQ-007 The block SHALL have output IN_READY, width 1: the block accepts a word this cycle.
REQ-008 The block SHALL have output X, width WIDTH: the registered voted word.
REQ-009 The block SHALL have output OUT_VALID, width 1: X holds a valid word.
REQ-010 The block SHALL have input OUT_READY, width 1: the consumer takes X this cycle.
REQ-011 The block SHALL have output ERR, width 1: one-cycle pulse flagging an accepted word whose lanes disagreed.
REQ-012 The block SHALL have output FATAL, width 1: level flag for the LOCK state.
REQ-013 The block SHALL have output ERR_CNT, width CNT_W: the mismatch counter.
REQ-014 The block SHALL have input ERR_CLR, width 1: clears ERR_CNT and releases LOCK.

Function
REQ-015 Vote SHALL be bitwise majority: (A&B)|(B&C)|(A&C).
REQ-016 Accept SHALL occur when IN_VALID=1 and IN_READY=1; pop SHALL occur when OUT_VALID=1 and OUT_READY=1.
REQ-017 State machine SHALL have three states: EMPTY, FULL and LOCK.
REQ-018 IN_READY SHALL equal 1 in EMPTY, SHALL equal OUT_READY in FULL, and SHALL equal 0 in LOCK; it is combinational and carries no IN_VALID dependency.
REQ-019 A word is mismatched when A!=B or B!=C; it is fatal when A!=B, B!=C and A!=C all hold (no two lanes agree).
REQ-020 A non-fatal accept SHALL register the vote into X, with OUT_VALID=1 on the next cycle and latency of exactly 1 cycle.
REQ-021 EMPTY SHALL go to FULL on a non-fatal accept, SHALL go to LOCK on a fatal accept, and SHALL otherwise stay.
REQ-022 FULL SHALL handle each case as follows:
- Pop with simultaneous non-fatal accept: X SHALL be replaced and the state SHALL stay FULL, giving back-to-back throughput.
- Pop with no accept: the state SHALL go to EMPTY.
- Pop with fatal accept: the state SHALL go to LOCK.
- No pop: X SHALL hold stable.
REQ-023 A fatal word SHALL never appear on X; in LOCK, OUT_VALID=0 and FATAL=1.
REQ-024 LOCK SHALL go to EMPTY on the cycle after ERR_CLR=1; ERR_CLR in EMPTY or FULL SHALL not change state.
REQ-025 ERR SHALL be 1 for exactly the cycle after each mismatched accept, fatal included.
REQ-026 ERR_CNT SHALL increment by 1 per mismatched accept and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-027 When ERR_CLR and an increment coincide, ERR_CNT SHALL become 0 (clear wins).
REQ-028 IN_VALID=1 while IN_READY=0 SHALL not be an accept; the producer holds A/B/C.

Reset
REQ-029 When RESET=1 at a CLK edge, the state SHALL go to EMPTY and X, OUT_VALID, ERR, FATAL and ERR_CNT SHALL all go to 0.
REQ-030 RESET SHALL take priority over accept, pop and ERR_CLR; a held word SHALL be discarded.
REQ-031 IN_READY SHALL be 1 on the first cycle after RESET deasserts.

Configuration
REQ-032 With macro TMR_ERRCNT_EN defined, ERR_CNT SHALL operate per REQ-026 and REQ-027.
REQ-033 Without TMR_ERRCNT_EN, the ERR_CNT port SHALL remain present, SHALL be driven constant 0, and SHALL have no counter register; all other behaviour SHALL be unchanged.

Verification
REQ-034 Bench SHALL cover: A=B=C=8'h5A with IN_VALID=1 in EMPTY -> next cycle X=8'h5A, OUT_VALID=1, ERR=0, ERR_CNT=0.
REQ-035 Bench SHALL cover: A=8'hF0, B=8'hF0, C=8'h0F accepted -> X=8'hF0, ERR pulses 1 cycle, ERR_CNT=1.
REQ-036 Bench SHALL cover: FULL with OUT_READY=1 and a new word on every cycle for 10 cycles -> IN_READY held 1, each word appears on X one cycle later with no gaps.
REQ-037 Bench SHALL cover: A=8'h01, B=8'h02, C=8'h04 accepted -> LOCK, FATAL=1, OUT_VALID=0, IN_READY=0; ERR_CLR=1 -> EMPTY, FATAL=0 next cycle.
REQ-038 Bench SHALL cover: 17 mismatched accepts with CNT_W=4 -> ERR_CNT=15; ERR_CLR coincident with the 18th mismatch -> ERR_CNT=0; without TMR_ERRCNT_EN, ERR_CNT stays 0 throughout.
REQ-039 Bench SHALL cover: RESET=1 while FULL with X=8'hAA -> next cycle OUT_VALID=0, X=0, ERR_CNT=0, IN_READY=1.

Source files
------------

// File: rtl/scs8hd_tmr_vote_reg.sv
// rtl/scs8hd_tmr_vote_reg.sv - TMR majority voter with one-word output register and error tracking
// Optional feature macro: TMR_ERRCNT_EN (enables the saturating mismatch counter on ERR_CNT).
module scs8hd_tmr_vote_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] X,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ERR,
  output logic             FATAL,
  output logic [CNT_W-1:0] ERR_CNT,
  input  logic             ERR_CLR
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] x_q;
  logic             err_q;
  logic [WIDTH-1:0] vote;
  logic             accept;
  logic             pop;
  logic             mismatch;
  logic             fatal_word;

  assign vote       = (A & B) | (B & C) | (A & C);
  assign mismatch   = (A != B) || (B != C);
  // No two lanes agree, so the majority vote is meaningless.
  assign fatal_word = (A != B) && (B != C) && (A != C);
  assign accept     = IN_VALID && IN_READY;
  assign pop        = OUT_VALID && OUT_READY;

  assign X         = x_q;
  assign OUT_VALID = (state == ST_FULL);
  assign FATAL     = (state == ST_LOCK);
  assign ERR       = err_q;

  // Ready depends only on state and the consumer, never on IN_VALID.
  always_comb begin
    IN_READY = 1'b0;
    case (state)
      ST_EMPTY: IN_READY = 1'b1;
      ST_FULL:  IN_READY = OUT_READY;
      default:  IN_READY = 1'b0;
    endcase
  end

  // Output-register state machine; a fatal word goes to LOCK instead of X.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_EMPTY;
      x_q   <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            if (fatal_word) begin
              state <= ST_LOCK;
            end else begin
              state <= ST_FULL;
              x_q   <= vote;
            end
          end
        end
        ST_FULL: begin
          if (accept) begin
            if (fatal_word) begin
              state <= ST_LOCK;
            end else begin
              x_q <= vote;
            end
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_LOCK: begin
          if (ERR_CLR) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // One-cycle error pulse for every accepted word with disagreeing lanes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && mismatch;
    end
  end

`ifdef TMR_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q;

  assign ERR_CNT = cnt_q;

  // Saturating mismatch counter; clear takes precedence over increment.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (ERR_CLR) begin
      cnt_q <= '0;
    end else if (accept && mismatch && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_scs8hd_tmr_vote_reg.sv
// tb/tb_scs8hd_tmr_vote_reg.sv - self-checking bench for scs8hd_tmr_vote_reg
module tb_scs8hd_tmr_vote_reg;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [WIDTH-1:0] A, B, C;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] X;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             ERR;
  logic             FATAL;
  logic [CNT_W-1:0] ERR_CNT;
  logic             ERR_CLR;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: a held word (0 or 1 entries), a lock flag, counter, pending error
  logic [WIDTH-1:0] held_q[$];
  bit               m_locked;
  int               m_cnt;
  bit               m_err;
  bit               cnt_en;

  scs8hd_tmr_vote_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .C(C),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .X(X), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ERR(ERR), .FATAL(FATAL), .ERR_CNT(ERR_CNT),
    .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] majority(input logic [WIDTH-1:0] a, b, c);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  function automatic int expected_ready();
    if (m_locked) return 0;
    if (held_q.size() == 0) return 1;
    return int'(OUT_READY);
  endfunction

  // one clock cycle with the current inputs: check ready, advance model, check outputs
  task automatic step();
    int agree;
    bit acc, pop, mism, fat;
    #1;
    check("in_ready", {31'd0, IN_READY}, expected_ready());
    acc   = IN_VALID && (expected_ready() == 1);
    pop   = (held_q.size() != 0) && OUT_READY;
    agree = int'(A == B) + int'(B == C) + int'(A == C);
    mism  = (agree < 3);
    fat   = (agree == 0);
    if (RESET) begin
      held_q.delete();
      m_locked = 0;
      m_cnt    = 0;
      m_err    = 0;
    end else begin
      m_err = acc && mism;
      if (cnt_en) begin
        if (ERR_CLR) m_cnt = 0;
        else if (acc && mism && m_cnt < CNT_MAX) m_cnt++;
      end
      if (m_locked) begin
        if (ERR_CLR) m_locked = 0;
      end else begin
        if (pop) held_q.delete();
        if (acc) begin
          held_q.delete();
          if (fat) m_locked = 1;
          else held_q.push_back(majority(A, B, C));
        end
      end
    end
    @(posedge CLK);
    #1;
    check("out_valid", {31'd0, OUT_VALID}, (held_q.size() != 0) ? 1 : 0);
    if (held_q.size() != 0) check("x", {24'd0, X}, {24'd0, held_q[0]});
    check("err", {31'd0, ERR}, m_err ? 1 : 0);
    check("fatal", {31'd0, FATAL}, m_locked ? 1 : 0);
    check("err_cnt", {28'd0, ERR_CNT}, m_cnt);
  endtask

  task automatic cyc(input bit rst, input bit iv, input logic [WIDTH-1:0] a, b, c,
                     input bit ordy, input bit clr);
    RESET = rst; IN_VALID = iv; A = a; B = b; C = c; OUT_READY = ordy; ERR_CLR = clr;
    step();
  endtask

  initial begin
`ifdef TMR_ERRCNT_EN
    cnt_en = 1;
`else
    cnt_en = 0;
`endif
    m_locked = 0; m_cnt = 0; m_err = 0;
    RESET = 1; IN_VALID = 0; A = 0; B = 0; C = 0; OUT_READY = 0; ERR_CLR = 0;
    @(posedge CLK); #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_x", {24'd0, X}, 0);
    check("rst_valid", {31'd0, OUT_VALID}, 0);

    // clean word into EMPTY
    cyc(0, 1, 8'h5A, 8'h5A, 8'h5A, 0, 0);
    check("clean_x", {24'd0, X}, 32'h5A);
    check("clean_err", {31'd0, ERR}, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // single-lane fault is outvoted, pulses ERR once
    cyc(0, 1, 8'hF0, 8'hF0, 8'h0F, 0, 0);
    check("vote_x", {24'd0, X}, 32'hF0);
    check("vote_err", {31'd0, ERR}, 1);
    check("vote_cnt", {28'd0, ERR_CNT}, cnt_en ? 1 : 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("err_pulse_end", {31'd0, ERR}, 0);
    check("hold_x", {24'd0, X}, 32'hF0);

    // back-to-back streaming through FULL
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] w;
      w = WIDTH'(8'h10 + i);
      cyc(0, 1, w, w, w, 1, 0);
      check("stream_x", {24'd0, X}, {24'd0, w});
    end
    cyc(0, 0, 0, 0, 0, 1, 0);

    // fatal word locks, ERR_CLR releases
    cyc(0, 1, 8'h01, 8'h02, 8'h04, 0, 0);
    check("lock_fatal", {31'd0, FATAL}, 1);
    cyc(0, 1, 8'h33, 8'h33, 8'h33, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("unlock_fatal", {31'd0, FATAL}, 0);

    // counter saturation then coincident clear
    cyc(0, 1, 8'h00, 8'h00, 8'h00, 1, 1);
    for (int i = 0; i < 17; i++) cyc(0, 1, 8'hA5, 8'hA5, WIDTH'(i), 1, 0);
    check("sat_cnt", {28'd0, ERR_CNT}, cnt_en ? CNT_MAX : 0);
    cyc(0, 1, 8'h11, 8'h22, 8'h22, 1, 1);
    check("clr_cnt", {28'd0, ERR_CNT}, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // reset discards a held word
    cyc(0, 1, 8'hAA, 8'hAA, 8'hAA, 0, 0);
    cyc(1, 1, 8'h55, 8'h55, 8'h55, 1, 1);
    check("rst_full_valid", {31'd0, OUT_VALID}, 0);
    check("rst_full_x", {24'd0, X}, 0);
    check("rst_full_ready", {31'd0, IN_READY}, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [WIDTH-1:0] base, m1, m2, a, b, c;
      int mode;
      base = WIDTH'($urandom);
      m1   = WIDTH'($urandom_range(1, 254));
      m2   = m1 + 1'b1;
      mode = $urandom_range(0, 5);
      a = base; b = base; c = base;
      case (mode)
        2: c = base ^ m1;
        3: a = base ^ m1;
        4: begin b = base ^ m1; c = base ^ m2; end
        default: ;
      endcase
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), a, b, c,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
